// File: rtl/serial_slice_alu.sv
// Multi-cycle 74181-style ALU: one SLICE-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a register. Result committed with a one-cycle valid pulse.
module serial_slice_alu #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_m,
  input  logic [2:0]       i_s,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin_n,
  output logic [WIDTH-1:0] o_f,
  output logic             o_cout_n,
  output logic             o_zero,
  output logic             o_out_valid
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_m;
  logic [2:0]       r_s;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_f;
  logic             r_cout_n;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [SLICE-1:0] w_a_s;
  logic [SLICE-1:0] w_b_s;
  logic [SLICE-1:0] w_x;
  logic [SLICE-1:0] w_y;
  logic [SLICE:0]   w_sum;
  logic [SLICE-1:0] w_logic;
  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_work_next;

  assign w_accept    = i_in_valid && (r_state != RUN);
  assign w_last      = (r_k == KW'(NSLICE - 1));
  assign o_in_ready  = (r_state != RUN);
  assign o_out_valid = (r_state == DONE);
  assign o_f         = r_f;
  assign o_cout_n    = r_cout_n;
  assign o_zero      = r_zero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = i_in_valid ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Slice datapath: the arithmetic ops reduce to X + Y + carry on the selected slice.
  always_comb begin
    w_a_s = r_a[r_k*SLICE +: SLICE];
    w_b_s = r_b[r_k*SLICE +: SLICE];
    w_x   = w_a_s;
    w_y   = '0;
    case (r_s)
      3'b000: begin w_x = w_a_s;         w_y = '0;     end
      3'b001: begin w_x = w_a_s;         w_y = w_b_s;  end
      3'b010: begin w_x = w_a_s;         w_y = ~w_b_s; end
      3'b011: begin w_x = w_a_s;         w_y = w_a_s;  end
      3'b100: begin w_x = w_a_s;         w_y = '1;     end
      3'b101: begin w_x = w_b_s;         w_y = '0;     end
      3'b110: begin w_x = ~w_a_s;        w_y = w_b_s;  end
      default: begin w_x = w_a_s | w_b_s; w_y = '0;    end
    endcase
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {{SLICE{1'b0}}, r_carry};

    case (r_s)
      3'b000: w_logic = ~w_a_s;
      3'b001: w_logic = ~(w_a_s | w_b_s);
      3'b010: w_logic = ~w_a_s & w_b_s;
      3'b011: w_logic = '0;
      3'b100: w_logic = ~(w_a_s & w_b_s);
      3'b101: w_logic = w_a_s ^ w_b_s;
      3'b110: w_logic = w_a_s & w_b_s;
      default: w_logic = w_a_s | w_b_s;
    endcase

    w_slice = r_m ? w_logic : w_sum[SLICE-1:0];
    w_work_next = r_work;
    w_work_next[r_k*SLICE +: SLICE] = w_slice;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m      <= 1'b0;
      r_s      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_work   <= '0;
      r_f      <= '0;
      r_cout_n <= 1'b1;
      r_zero   <= 1'b1;
    end else if (w_accept) begin
      r_m     <= i_m;
      r_s     <= i_s;
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= ~i_cin_n;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_work  <= w_work_next;
      r_carry <= w_sum[SLICE];
      // Index wraps to 0 after the last slice so it never points past the operand.
      r_k     <= w_last ? '0 : r_k + KW'(1);
      if (w_last) begin
        r_f      <= w_work_next;
        r_cout_n <= r_m ? 1'b1 : ~w_sum[SLICE];
        r_zero   <= (w_work_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_slice_alu.sv
// Bench for serial_slice_alu: three configurations (8/2, 4/1, 8/8) share one stimulus
// stream and are each checked every cycle against a whole-word arithmetic model.
module tb_serial_slice_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       m;
  logic [2:0] s;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin_n;

  logic [7:0] f0, f2;
  logic [3:0] f1;
  logic       c0, c1, c2, z0, z1, z2, r0, r1, r2, v0, v1, v2;

  logic [7:0] f_a [3];
  logic       cout_a [3];
  logic       zero_a [3];
  logic       rdy_a [3];
  logic       ov_a [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  serial_slice_alu #(.WIDTH(8), .SLICE(2)) u_8x2 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(r0), .i_m(m), .i_s(s),
    .i_a(a), .i_b(b), .i_cin_n(cin_n), .o_f(f0), .o_cout_n(c0), .o_zero(z0), .o_out_valid(v0));

  serial_slice_alu #(.WIDTH(4), .SLICE(1)) u_4x1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(r1), .i_m(m), .i_s(s),
    .i_a(a[3:0]), .i_b(b[3:0]), .i_cin_n(cin_n), .o_f(f1), .o_cout_n(c1), .o_zero(z1),
    .o_out_valid(v1));

  serial_slice_alu #(.WIDTH(8), .SLICE(8)) u_8x8 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(r2), .i_m(m), .i_s(s),
    .i_a(a), .i_b(b), .i_cin_n(cin_n), .o_f(f2), .o_cout_n(c2), .o_zero(z2), .o_out_valid(v2));

  always_comb begin
    f_a[0] = f0;  f_a[1] = {4'b0, f1};  f_a[2] = f2;
    cout_a[0] = c0;  cout_a[1] = c1;  cout_a[2] = c2;
    zero_a[0] = z0;  zero_a[1] = z1;  zero_a[2] = z2;
    rdy_a[0] = r0;  rdy_a[1] = r1;  rdy_a[2] = r2;
    ov_a[0] = v0;  ov_a[1] = v1;  ov_a[2] = v2;
  end

  function automatic void chk(string nm, int idx, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h, expected %0h", nm, idx, cyc, act, exp);
    end
  endfunction

  // Whole-word reference: returns {cout_n, f} for a w-bit ALU.
  function automatic logic [8:0] model(int w, bit mm, bit [2:0] ss, bit [7:0] aa8, bit [7:0] bb8,
                                       bit cn);
    int mask, aa, bb, x, y, r, c;
    mask = (1 << w) - 1;
    aa = int'(aa8) & mask;
    bb = int'(bb8) & mask;
    c = cn ? 0 : 1;
    if (mm) begin
      case (ss)
        3'd0: r = ~aa;
        3'd1: r = ~(aa | bb);
        3'd2: r = ~aa & bb;
        3'd3: r = 0;
        3'd4: r = ~(aa & bb);
        3'd5: r = aa ^ bb;
        3'd6: r = aa & bb;
        default: r = aa | bb;
      endcase
      return {1'b1, 8'(r & mask)};
    end
    case (ss)
      3'd0: begin x = aa; y = 0; end
      3'd1: begin x = aa; y = bb; end
      3'd2: begin x = aa; y = ~bb & mask; end
      3'd3: begin x = aa; y = aa; end
      3'd4: begin x = aa; y = mask; end
      3'd5: begin x = bb; y = 0; end
      3'd6: begin x = ~aa & mask; y = bb; end
      default: begin x = aa | bb; y = 0; end
    endcase
    r = x + y + c;
    return {~(((r >> w) & 1) != 0), 8'(r & mask)};
  endfunction

  int         ws [3] = '{8, 4, 8};
  int         ns [3] = '{4, 4, 1};
  bit         pend [3];
  int         due [3];
  logic [8:0] pres [3];
  logic [7:0] ef [3];
  bit         ec [3];
  bit         ez [3];

  // Per-cycle compare: an accepted op is owed exactly NSLICE+1 samples later; busy until then.
  always @(negedge clk) begin
    bit exp_ov, exp_rdy;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pend[i] = 1'b0;
        ef[i] = 8'h00;  ec[i] = 1'b1;  ez[i] = 1'b1;
        exp_ov = 1'b0;  exp_rdy = 1'b1;
      end else begin
        exp_ov = pend[i] && (due[i] == cyc);
        if (exp_ov) begin
          ef[i] = pres[i][7:0];
          ec[i] = pres[i][8];
          ez[i] = (pres[i][7:0] == 8'h00);
          pend[i] = 1'b0;
        end
        exp_rdy = !pend[i];
      end
      chk("out_valid", i, int'(ov_a[i]), int'(exp_ov));
      chk("in_ready", i, int'(rdy_a[i]), int'(exp_rdy));
      chk("f", i, int'(f_a[i]), int'(ef[i]));
      chk("cout_n", i, int'(cout_a[i]), int'(ec[i]));
      chk("zero", i, int'(zero_a[i]), int'(ez[i]));
      if (!rst && in_valid && exp_rdy) begin
        pres[i] = model(ws[i], m, s, a, b, cin_n);
        pend[i] = 1'b1;
        due[i]  = cyc + ns[i] + 1;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!(r0 && r1 && r2 && !v0 && !v1 && !v2) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout", 0, int'(t < 20), 1);
  endtask

  task automatic run_op(string nm, bit tm, bit [2:0] ts, bit [7:0] ta, bit [7:0] tb_v, bit tc,
                        bit [7:0] xf, bit xc, bit xz);
    int n = 0;
    wait_idle();
    in_valid = 1'b1;  m = tm;  s = ts;  a = ta;  b = tb_v;  cin_n = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom);  b = 8'($urandom);  s = 3'($urandom);  m = 1'($urandom);
    cin_n = 1'($urandom);
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (v0) break;
    end
    chk({nm, "_latency"}, 0, n, 5);
    chk({nm, "_f"}, 0, int'(f0), int'(xf));
    chk({nm, "_cout_n"}, 0, int'(c0), int'(xc));
    chk({nm, "_zero"}, 0, int'(z0), int'(xz));
    chk({nm, "_f"}, 2, int'(f2), int'(xf));
    chk({nm, "_cout_n"}, 2, int'(c2), int'(xc));
  endtask

  initial begin
    int cnt;
    rst = 1'b1;  in_valid = 1'b0;  m = 1'b0;  s = 3'd0;  a = 8'h00;  b = 8'h00;  cin_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f", 0, int'(f0), 0);
    chk("rst_cout_n", 0, int'(c0), 1);
    chk("rst_zero", 0, int'(z0), 1);
    chk("rst_ready", 0, int'(r0), 1);
    chk("rst_ov", 0, int'(v0), 0);
    rst = 1'b0;

    run_op("add", 1'b0, 3'b001, 8'hB7, 8'h5C, 1'b1, 8'h13, 1'b0, 1'b0);
    run_op("sub", 1'b0, 3'b010, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    run_op("inc", 1'b0, 3'b000, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    run_op("xor", 1'b1, 3'b101, 8'hF0, 8'hFF, 1'b1, 8'h0F, 1'b1, 1'b0);

    // Continuous request: the 8x2 unit should complete one op every 5 cycles.
    wait_idle();
    in_valid = 1'b1;  m = 1'b0;  s = 3'b001;  a = 8'h21;  b = 8'h43;  cin_n = 1'b0;
    cnt = 0;
    repeat (21) begin
      @(negedge clk);
      cnt += int'(v0);
    end
    chk("b2b_count", 0, cnt, 4);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Reset during the second RUN cycle aborts the op.
    wait_idle();
    in_valid = 1'b1;  m = 1'b0;  s = 3'b011;  a = 8'h55;  b = 8'h00;  cin_n = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(v0);
    end
    chk("abort_ov", 0, cnt, 0);
    chk("abort_f", 0, int'(f0), 0);

    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = 1'($urandom_range(0, 1));
      m        = 1'($urandom);
      s        = 3'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      cin_n    = 1'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0;  in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
